// File: rtl/mult_product_accumulator.sv
// Block-summing reduction stage behind the shift-and-add multiplier: adds blk_len
// unsigned products into a saturating accumulator and hands the total downstream.
module mult_product_accumulator #(
    parameter int PW = 16,
    parameter int AW = 24,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [PW-1:0] in_data,
    output logic          in_ready,
    input  logic [CW-1:0] blk_len,
    input  logic          flush,
    output logic          out_valid,
    output logic [AW-1:0] out_data,
    output logic [CW:0]   out_count,
    output logic          out_ovf,
    input  logic          out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CW:0]   MAX_LEN = (CW+1)'(2**CW);
    localparam logic [CW:0]   ONE_CNT = (CW+1)'(1);
    localparam logic [AW-1:0] ACC_SAT = {AW{1'b1}};

    state_t        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [CW:0]   count_q, count_d;
    logic [CW:0]   len_q, len_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] out_data_q, out_data_d;
    logic [CW:0]   out_count_q, out_count_d;
    logic          out_ovf_q, out_ovf_d;

    logic          beat;
    logic [AW:0]   sum_wide;
    logic          sat_hit;
    logic [AW-1:0] acc_sat;
    logic [CW:0]   count_inc;
    logic [CW:0]   len_sample;
    logic [AW-1:0] in_ext;

    assign in_ready  = (state_q != HOLD) & ~rst;
    assign out_valid = (state_q == HOLD);
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

    assign beat       = in_valid & in_ready;
    assign in_ext     = AW'(in_data);
    // One extra bit catches the carry out of the accumulator; all-ones is sticky
    // because adding a non-negative value to it either carries or stays put.
    assign sum_wide   = {1'b0, acc_q} + (AW+1)'(in_data);
    assign sat_hit    = sum_wide[AW];
    assign acc_sat    = sat_hit ? ACC_SAT : sum_wide[AW-1:0];
    assign count_inc  = count_q + ONE_CNT;
    assign len_sample = (blk_len == '0) ? MAX_LEN : {1'b0, blk_len};

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        len_d       = len_q;
        ovf_d       = ovf_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        case (state_q)
            IDLE: begin
                // flush is deliberately ignored here so an empty block never reaches the output
                if (beat) begin
                    acc_d   = in_ext;
                    count_d = ONE_CNT;
                    len_d   = len_sample;
                    ovf_d   = 1'b0;
                    if (len_sample == ONE_CNT) begin
                        state_d     = HOLD;
                        out_data_d  = in_ext;
                        out_count_d = ONE_CNT;
                        out_ovf_d   = 1'b0;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            ACC: begin
                if (beat) begin
                    acc_d   = acc_sat;
                    count_d = count_inc;
                    ovf_d   = ovf_q | sat_hit;
                    if ((count_inc == len_q) || flush) begin
                        state_d     = HOLD;
                        out_data_d  = acc_sat;
                        out_count_d = count_inc;
                        out_ovf_d   = ovf_q | sat_hit;
                    end
                end else if (flush) begin
                    state_d     = HOLD;
                    out_data_d  = acc_q;
                    out_count_d = count_q;
                    out_ovf_d   = ovf_q;
                end
            end
            HOLD: begin
                // Result fields stay put after the handshake; only out_valid drops.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            len_q       <= len_d;
            ovf_q       <= ovf_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule
